// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter slice.
//   - arb_state_e : FSM state encoding (also driven onto the debug port)
//   - DEF_FUN_WIDTH / DEF_TIMEOUT_CYC : default ALU function width and timeout
//   - cnt_width() : width of a counter that must reach TIMEOUT_CYC
//   - ptr_width() : width of a requester index (at least 1 bit)
package alu_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GATE_ON = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_e;

    localparam int DEF_FUN_WIDTH   = 4;
    localparam int DEF_TIMEOUT_CYC = 8;

    function automatic int cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam int DEF_CNT_WIDTH = cnt_width(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot requester pick.
//   Default build: round-robin, search starts at rr_ptr and wraps.
//   With ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
//   and the rr_ptr port does not exist.
// Ports:
//   req      in  NUM_REQ  request levels
//   rr_ptr   in  PTR_W    first index searched (round-robin build only)
//   any      out 1        at least one request is high
//   pick_oh  out NUM_REQ  one-hot winner
//   pick_idx out PTR_W    binary index of the winner
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]   rr_ptr,
`endif
    output logic               any,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [PTR_W-1:0]   pick_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any      = 1'b0;
        pick_oh  = '0;
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any        = 1'b1;
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
                pick_idx   = PTR_W'(i);
            end
        end
    end
`else
    // Visit rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first hit wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        any      = 1'b0;
        pick_oh  = '0;
        pick_idx = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any          = 1'b1;
                pick_oh[idx] = 1'b1;
                pick_idx     = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NUM_REQ requesters (REF_CLK domain).
// Sequence per operation: IDLE (arbitrate, capture operands, raise clk_en)
//   -> GATE_ON (let the gated clock settle) -> ISSUE (alu_en pulse)
//   -> WAIT (ALU valid or timeout) -> RESP (one-cycle rsp_valid) -> IDLE.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority; otherwise round-robin starting at rr_ptr.
// Ports:
//   CLK, RST              clock; synchronous active-low reset
//   req/req_a/req_b/req_fun  per-requester request level and flattened operands
//   gnt                   one-hot grant, GATE_ON through RESP
//   rsp_valid/rsp_data/rsp_err  one-cycle response strobe, result, timeout flag
//   alu_a/alu_b/alu_fun/alu_en  captured operands and issue pulse to the ALU
//   clk_en                Clock_Gating enable
//   alu_out/alu_out_valid ALU result and its registered valid
//   state_dbg             current FSM state (arb_state_e encoding)
// Handshake: a requester holds req until it sees its rsp_valid bit; operands
// are captured at grant, and alu_out_valid is honoured only in WAIT.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int OPERAND_WIDTH = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = DEF_FUN_WIDTH,
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*FUN_WIDTH-1:0]      req_fun,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [ALU_OUT_WIDTH-1:0]          rsp_data,
    output logic                              rsp_err,
    output logic [OPERAND_WIDTH-1:0]          alu_a,
    output logic [OPERAND_WIDTH-1:0]          alu_b,
    output logic [FUN_WIDTH-1:0]              alu_fun,
    output logic                              alu_en,
    output logic                              clk_en,
    input  logic [ALU_OUT_WIDTH-1:0]          alu_out,
    input  logic                              alu_out_valid,
    output logic [2:0]                        state_dbg
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    arb_state_e                state_q, state_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [ALU_OUT_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [OPERAND_WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [OPERAND_WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [FUN_WIDTH-1:0]      alu_fun_q, alu_fun_d;
    logic                      alu_en_q, alu_en_d;
    logic                      clk_en_q, clk_en_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          cnt_inc;

    logic                      pick_any;
    logic [NUM_REQ-1:0]        pick_oh;
    logic [PTR_W-1:0]          pick_idx;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          win_q, win_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req      (req),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .rr_ptr   (rr_ptr_q),
`endif
        .any      (pick_any),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        alu_en_d    = 1'b0;
        clk_en_d    = clk_en_q;
        cnt_d       = cnt_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    alu_a_d   = req_a[int'(pick_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
                    alu_b_d   = req_b[int'(pick_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
                    alu_fun_d = req_fun[int'(pick_idx)*FUN_WIDTH +: FUN_WIDTH];
                    gnt_d     = pick_oh;
                    clk_en_d  = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    win_d     = pick_idx;
`endif
                    state_d   = ST_GATE_ON;
                end else begin
                    clk_en_d  = 1'b0;
                end
            end
            ST_GATE_ON: begin
                // Outputs are registered, so alu_en is set on the way into
                // ISSUE and is therefore high for exactly the ISSUE cycle.
                alu_en_d = 1'b1;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid result takes precedence over a coincident timeout.
                if (alu_out_valid) begin
                    rsp_data_d  = alu_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = gnt_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = gnt_q;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                gnt_d    = '0;
                clk_en_d = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
`endif
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            alu_en_q    <= 1'b0;
            clk_en_q    <= 1'b0;
            cnt_q       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
            win_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            alu_en_q    <= alu_en_d;
            clk_en_q    <= clk_en_d;
            cnt_q       <= cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign alu_en    = alu_en_q;
    assign clk_en    = clk_en_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter (default parameters).
// Stimulus pushes expected responses {rsp_valid, rsp_err, rsp_data} into
// exp_q; a monitor on the falling edge pops and compares every response.
// A small ALU model answers alu_en after alu_delay cycles (0 = never).
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OW      = 8;
    localparam int AW      = 16;
    localparam int FW      = 4;
    localparam int EW      = NUM_REQ + 1 + AW;

    localparam logic [FW-1:0] FUN_ADD = 4'd0;
    localparam logic [FW-1:0] FUN_SUB = 4'd1;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*OW-1:0]    req_a;
    logic [NUM_REQ*OW-1:0]    req_b;
    logic [NUM_REQ*FW-1:0]    req_fun;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [AW-1:0]            rsp_data;
    logic                     rsp_err;
    logic [OW-1:0]            alu_a;
    logic [OW-1:0]            alu_b;
    logic [FW-1:0]            alu_fun;
    logic                     alu_en;
    logic                     clk_en;
    logic [AW-1:0]            alu_out;
    logic                     alu_out_valid;
    logic [2:0]               state_dbg;

    logic [EW-1:0]            exp_q[$];
    int                       pass_cnt;
    int                       check_cnt;
    int                       alu_delay;

    alu_arbiter dut (
        .CLK           (clk),
        .RST           (rst_n),
        .req           (req),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_fun       (req_fun),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_fun       (alu_fun),
        .alu_en        (alu_en),
        .clk_en        (clk_en),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [NUM_REQ-1:0] oh, input logic err, input logic [AW-1:0] data);
        exp_q.push_back({oh, err, data});
    endtask

    task automatic set_opnd(input int idx, input logic [OW-1:0] a, input logic [OW-1:0] b,
                            input logic [FW-1:0] fun);
        req_a[idx*OW +: OW]   = a;
        req_b[idx*OW +: OW]   = b;
        req_fun[idx*FW +: FW] = fun;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_alu_a"},     32'(alu_a),     32'd0);
        check({tag, "_alu_b"},     32'(alu_b),     32'd0);
        check({tag, "_alu_fun"},   32'(alu_fun),   32'd0);
        check({tag, "_alu_en"},    32'(alu_en),    32'd0);
        check({tag, "_clk_en"},    32'(clk_en),    32'd0);
        check({tag, "_state"},     32'(state_dbg), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (state_dbg != 3'd0 && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) check("wait_idle_timeout", 32'(state_dbg), 32'd0);
    endtask

    // Raise reqmask for one grant, drop it, and measure cycles to rsp_valid.
    task automatic run_op(input string name, input logic [NUM_REQ-1:0] reqmask,
                          input int delay, input int exp_lat);
        int lat;
        wait_idle();
        @(negedge clk);
        alu_delay = delay;
        req       = reqmask;
        lat       = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) req = '0;
            if (rsp_valid != '0) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // ---------------- ALU model ----------------
    function automatic logic [AW-1:0] alu_calc(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                               input logic [FW-1:0] f);
        case (f)
            FUN_ADD: alu_calc = AW'(a) + AW'(b);
            FUN_SUB: alu_calc = AW'(a) - AW'(b);
            default: alu_calc = '0;
        endcase
    endfunction

    initial begin
        logic [AW-1:0] res;
        alu_out       = '0;
        alu_out_valid = 1'b0;
        forever begin
            tick();
            if (alu_en && alu_delay > 0) begin
                res = alu_calc(alu_a, alu_b, alu_fun);
                repeat (alu_delay) @(posedge clk);
                #1;
                alu_out       = res;
                alu_out_valid = 1'b1;
                @(posedge clk);
                #1;
                alu_out       = '0;
                alu_out_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(e[EW-1 -: NUM_REQ]));
                    check("rsp_err",   32'(rsp_err),   32'(e[AW]));
                    check("rsp_data",  32'(rsp_data),  32'(e[AW-1:0]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int stamp[4];
        int n;
        pass_cnt  = 0;
        check_cnt = 0;
        alu_delay = 1;
        rst_n     = 1'b0;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        req_fun   = '0;

        apply_reset("reset");

        // Single request: 5 + 3 = 8, cycle-by-cycle timing.
        @(negedge clk);
        set_opnd(0, 8'd5, 8'd3, FUN_ADD);
        alu_delay = 1;
        req       = 4'b0001;
        push_exp(4'b0001, 1'b0, 16'd8);
        tick();
        check("single_gnt_t1",    32'(gnt),       32'h1);
        check("single_clken_t1",  32'(clk_en),    32'd1);
        check("single_aluen_t1",  32'(alu_en),    32'd0);
        check("single_state_t1",  32'(state_dbg), 32'd1);
        req = '0;
        tick();
        check("single_aluen_t2",  32'(alu_en),    32'd1);
        check("single_alu_a",     32'(alu_a),     32'd5);
        check("single_alu_b",     32'(alu_b),     32'd3);
        check("single_alu_fun",   32'(alu_fun),   32'(FUN_ADD));
        tick();
        check("single_aluen_t3",  32'(alu_en),    32'd0);
        check("single_clken_t3",  32'(clk_en),    32'd1);
        tick();
        check("single_rsp_t4",    32'(rsp_valid), 32'h1);
        check("single_clken_t4",  32'(clk_en),    32'd1);
        tick();
        check("single_clken_t5",  32'(clk_en),    32'd0);
        check("single_gnt_t5",    32'(gnt),       32'd0);
        check("single_rspv_t5",   32'(rsp_valid), 32'd0);

        // Contention from a fresh reset: all four held high.
        apply_reset("reset2");
        set_opnd(0, 8'd10, 8'd0, FUN_ADD);
        set_opnd(1, 8'd20, 8'd1, FUN_ADD);
        set_opnd(2, 8'd30, 8'd2, FUN_ADD);
        set_opnd(3, 8'd40, 8'd3, FUN_ADD);
`ifdef ALU_ARB_FIXED_PRIO_EN
        push_exp(4'b0001, 1'b0, 16'd10);
        push_exp(4'b0001, 1'b0, 16'd10);
        push_exp(4'b0001, 1'b0, 16'd10);
        push_exp(4'b0001, 1'b0, 16'd10);
`else
        push_exp(4'b0001, 1'b0, 16'd10);
        push_exp(4'b0010, 1'b0, 16'd21);
        push_exp(4'b0100, 1'b0, 16'd32);
        push_exp(4'b1000, 1'b0, 16'd43);
`endif
        @(negedge clk);
        alu_delay = 1;
        req       = 4'b1111;
        n         = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (rsp_valid != '0) begin
                stamp[n] = k;
                n++;
                if (n == 4) begin
                    req = '0;
                    break;
                end
            end
        end
        req = '0;
        check("contention_count", 32'(n), 32'd4);
        if (n == 4) begin
            check("contention_first", 32'(stamp[0]), 32'd4);
            for (int i = 1; i < 4; i++)
                check("contention_spacing", 32'(stamp[i] - stamp[i-1]), 32'd5);
        end

        // Timeout: ALU never answers.
        set_opnd(2, 8'd1, 8'd1, FUN_ADD);
        push_exp(4'b0100, 1'b1, 16'd0);
        run_op("timeout", 4'b0100, 0, 11);
        tick();
        check("timeout_back_idle", 32'(state_dbg), 32'd0);

        // Valid arrives on the cycle the counter reaches TIMEOUT_CYC: 7 - 6 = 1.
        set_opnd(1, 8'd7, 8'd6, FUN_SUB);
        push_exp(4'b0010, 1'b0, 16'd1);
        run_op("boundary", 4'b0010, 8, 11);

        // Reset in WAIT: no response, everything cleared.
        wait_idle();
        @(negedge clk);
        set_opnd(0, 8'd50, 8'd50, FUN_ADD);
        alu_delay = 0;
        req       = 4'b0001;
        repeat (4) tick();
        req = '0;
        check("midreset_in_wait", 32'(state_dbg), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("midreset_no_rsp", 32'(rsp_valid), 32'd0);

        // rr_ptr back at 0: with 0 and 2 requesting, 0 wins. 1 + 2 = 3.
        set_opnd(0, 8'd1, 8'd2, FUN_ADD);
        set_opnd(2, 8'd4, 8'd4, FUN_ADD);
        push_exp(4'b0001, 1'b0, 16'd3);
        @(negedge clk);
        alu_delay = 1;
        req       = 4'b0101;
        tick();
        check("post_reset_gnt", 32'(gnt), 32'h1);
        req = '0;
        repeat (4) tick();

        // Requester 2 alone after the reset: 100 + 50 = 150.
        set_opnd(2, 8'd100, 8'd50, FUN_ADD);
        push_exp(4'b0100, 1'b0, 16'd150);
        run_op("req2", 4'b0100, 1, 4);

        // Drop req and scramble operands right after grant: 9 + 4 = 13.
        wait_idle();
        @(negedge clk);
        set_opnd(1, 8'd9, 8'd4, FUN_ADD);
        alu_delay = 1;
        req       = 4'b0010;
        push_exp(4'b0010, 1'b0, 16'd13);
        tick();
        check("drop_gnt", 32'(gnt), 32'h2);
        req = '0;
        set_opnd(1, 8'hff, 8'hee, FUN_SUB);
        tick();
        check("drop_alu_a",  32'(alu_a),  32'd9);
        check("drop_alu_b",  32'(alu_b),  32'd4);
        check("drop_alu_en", 32'(alu_en), 32'd1);
        repeat (2) tick();
        check("drop_rsp", 32'(rsp_valid), 32'h2);

        repeat (4) tick();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
